// File: rtl/audio_codec_pkg.sv
// rtl/audio_codec_pkg.sv - shared audio codec widths and capture state encoding
package audio_codec_pkg;

    localparam int AUDIO_WORD_W = 32;
    localparam int AUDIO_CH_W   = 16;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SHIFT      = 2'd1,
        DONE       = 2'd2
    } adc_state_t;

endpackage

// File: rtl/audio_sync_edge.sv
// rtl/audio_sync_edge.sv - multi-flop synchronizer with single-cycle rising-edge pulse
module audio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/audio_input_adc.sv
// rtl/audio_input_adc.sv - codec ADC serial capture into one stereo word per LRCK frame
module audio_input_adc
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Data_Valid,
    output logic                  Frame_Error
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic bclk_rise;
    logic lrck_rise;
    logic dat_bit;

    logic [SYNC_STAGES-1:0] dat_sync_q;

    adc_state_t             state_q, state_d;
    logic [CNT_W-1:0]       bits_q, bits_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk_i  (Clk),
        .rst_i  (reset),
        .d_i    (AUD_BCLK),
        .rise_o (bclk_rise)
    );

    audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk_i  (Clk),
        .rst_i  (reset),
        .d_i    (AUD_ADCLRCK),
        .rise_o (lrck_rise)
    );

    // Same depth as the clock paths so the data bit lines up with bclk_rise.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            dat_sync_q <= '0;
        end else begin
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
        end
    end

    assign dat_bit = dat_sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
            bits_q  <= LAST_BIT;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (lrck_rise) begin
                    state_d = SHIFT;
                    bits_d  = LAST_BIT;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                // A new frame start beats a coincident bit edge and resyncs.
                if (lrck_rise) begin
                    ferr_d  = 1'b1;
                    bits_d  = LAST_BIT;
                    shift_d = '0;
                end else if (bclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], dat_bit};
                    if (bits_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bits_d = bits_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                data_d  = shift_q;
                valid_d = 1'b1;
                bits_d  = LAST_BIT;
                if (lrck_rise) begin
                    state_d = SHIFT;
                    shift_d = '0;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            default: begin
                state_d = WAIT_FRAME;
                bits_d  = LAST_BIT;
            end
        endcase
    end

    assign Data        = data_q;
    assign Data_Valid  = valid_q;
    assign Frame_Error = ferr_q;

endmodule

// File: tb/tb_audio_input_adc.sv
// tb/tb_audio_input_adc.sv - scoreboard bench for audio_input_adc
module tb_audio_input_adc;

    localparam int DW      = 32;
    localparam int SS      = 2;
    localparam int MAX_LAT = SS + 3;

    logic          Clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          AUD_BCLK    = 1'b0;
    logic          AUD_ADCLRCK = 1'b0;
    logic          AUD_ADCDAT  = 1'b0;
    logic [DW-1:0] Data;
    logic          Data_Valid;
    logic          Frame_Error;

    int checks   = 0;
    int errors   = 0;
    int ferr_seen = 0;
    int ferr_exp  = 0;
    int cyc       = 0;
    int mark_cyc  = 0;
    bit prev_valid = 1'b0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_last = '0;

    audio_input_adc #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .Data        (Data),
        .Data_Valid  (Data_Valid),
        .Frame_Error (Frame_Error)
    );

    always #10ns Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each Data_Valid, otherwise Data must hold.
    always @(negedge Clk) begin
        int lat;
        if (reset) begin
            exp_last   = '0;
            prev_valid = 1'b0;
        end else begin
            if (Frame_Error) ferr_seen++;
            if (Data_Valid) begin
                check("valid_single_cycle", 64'(prev_valid), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%h required=none", Data);
                end else begin
                    exp_last = exp_q.pop_front();
                    check("data", 64'(Data), 64'(exp_last));
                    lat = cyc - mark_cyc;
                    checks++;
                    if (lat < 0 || lat > MAX_LAT) begin
                        errors++;
                        $display("FAIL latency actual=%0d required<=%0d", lat, MAX_LAT);
                    end
                end
            end else begin
                check("data_hold", 64'(Data), 64'(exp_last));
            end
            prev_valid = Data_Valid;
        end
    end

    // Drives n BCLK periods, bits MSB first from bits[n-1]; LRCK rises at bit 0, falls at bit 16.
    task automatic drive_frame(input logic [63:0] bits, input int n, input bit coinc,
                               input int mark_idx, input int half, input bit jit);
        int j;
        for (int i = 0; i < n; i++) begin
            j = jit ? int'($urandom_range(2)) - 1 : 0;
            AUD_ADCDAT = bits[n-1-i];
            if (i == 0 && !coinc) AUD_ADCLRCK = 1'b1;
            if (i == 16) AUD_ADCLRCK = 1'b0;
            #((half + 20 * j) * 1ns);
            if (i == 0 && coinc) AUD_ADCLRCK = 1'b1;
            AUD_BCLK = 1'b1;
            if (i == mark_idx) mark_cyc = cyc;
            #((half - 20 * j) * 1ns);
            AUD_BCLK = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int half, input bit jit);
        exp_q.push_back(w);
        drive_frame({32'h0, w}, 32, 1'b0, 31, half, jit);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge Clk);
        check(name, 64'(exp_q.size()), 64'd0);
        #3ns;
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] s;

        #3ns;
        check("reset_data", 64'(Data), 64'd0);
        check("reset_valid", 64'(Data_Valid), 64'd0);
        check("reset_ferr", 64'(Frame_Error), 64'd0);
        #100ns;
        reset = 1'b0;

        send_word(32'hA5A5_0F0F, 160, 1'b0);
        wait_drain("drain_single");
        check("ferr_single", 64'(ferr_seen), 64'(ferr_exp));

        send_word(32'h8000_0001, 160, 1'b0);
        send_word(32'h7FFF_FFFE, 160, 1'b0);
        wait_drain("drain_b2b");

        drive_frame({32'h0, 32'hFFFF_FFFF}, 20, 1'b0, -1, 160, 1'b0);
        ferr_exp++;
        send_word(32'h1234_5678, 160, 1'b0);
        wait_drain("drain_early");
        check("ferr_early", 64'(ferr_seen), 64'(ferr_exp));

        drive_frame(64'(32'hDEAD_BEEF >> 22), 10, 1'b0, -1, 160, 1'b0);
        reset = 1'b1;
        #1ns;
        check("midreset_data", 64'(Data), 64'd0);
        check("midreset_valid", 64'(Data_Valid), 64'd0);
        check("midreset_ferr", 64'(Frame_Error), 64'd0);
        AUD_ADCLRCK = 1'b0;
        AUD_ADCDAT  = 1'b0;
        #49ns;
        reset = 1'b0;
        send_word(32'h0000_FFFF, 160, 1'b0);
        wait_drain("drain_reset");
        check("ferr_reset", 64'(ferr_seen), 64'(ferr_exp));

        w = 32'hC33C_5AA5;
        s = {24'h0, ~w[31], w, 7'h55};
        exp_q.push_back(w);
        drive_frame(s, 40, 1'b1, 32, 160, 1'b0);
        w = 32'h0F1E_2D3C;
        s = {24'h0, ~w[31], w, 7'h2A};
        exp_q.push_back(w);
        drive_frame(s, 40, 1'b1, 32, 160, 1'b0);
        wait_drain("drain_coincident");
        check("ferr_coincident", 64'(ferr_seen), 64'(ferr_exp));

        for (int f = 0; f < 250; f++) begin
            w = $urandom;
            send_word(w, 40, 1'b1);
        end
        wait_drain("drain_jitter");

        check("ferr_total", 64'(ferr_seen), 64'(ferr_exp));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
